// File: rtl/id_operand_fetch_if.sv
// id_operand_fetch_if: decoder, regfile, forwarding and ID/EX buffer signals of the operand-fetch stage.
// slave is the stage itself; master is whoever surrounds it (decoder, regfile, EX/MEM, execute).
interface id_operand_fetch_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_ctrl;
    logic [XLEN-1:0] in_imm;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic            in_use_rs1;
    logic            in_use_rs2;
    logic [AW-1:0]   in_rd;
    logic            in_rd_we;
    logic            re1;
    logic            re2;
    logic [AW-1:0]   r_addr1;
    logic [AW-1:0]   r_addr2;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    logic            ex_we;
    logic [AW-1:0]   ex_waddr;
    logic [XLEN-1:0] ex_wdata;
    logic            ex_is_load;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_ctrl;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [AW-1:0]   out_rd;
    logic            out_rd_we;

    modport slave (
        input  in_valid, in_pc, in_ctrl, in_imm, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_we,
        input  r_data1, r_data2, ex_we, ex_waddr, ex_wdata, ex_is_load, mem_we, mem_waddr, mem_wdata, out_ready,
        output in_ready, re1, re2, r_addr1, r_addr2,
        output out_valid, out_pc, out_ctrl, out_imm, out_op1, out_op2, out_rd, out_rd_we
    );

    modport master (
        output in_valid, in_pc, in_ctrl, in_imm, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_we,
        output r_data1, r_data2, ex_we, ex_waddr, ex_wdata, ex_is_load, mem_we, mem_waddr, mem_wdata, out_ready,
        input  in_ready, re1, re2, r_addr1, r_addr2,
        input  out_valid, out_pc, out_ctrl, out_imm, out_op1, out_op2, out_rd, out_rd_we
    );
endinterface

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: regfile read, EX/MEM forwarding, load-use stall and single-entry ID/EX buffer.
// Define IDOF_PERF_CNT_EN to add the stall_cnt load-use stall counter output.
module id_operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    id_operand_fetch_if.slave   bus
`ifdef IDOF_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_pc;
    logic [31:0]     r_ctrl;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [AW-1:0]   r_rd;
    logic            r_rd_we;

    logic            w_zero1, w_zero2;
    logic            w_ex1, w_ex2;
    logic            w_mem1, w_mem2;
    logic            w_hazard;
    logic            w_accept;
    logic [XLEN-1:0] w_op1, w_op2;

    assign bus.re1     = bus.in_valid & bus.in_use_rs1;
    assign bus.re2     = bus.in_valid & bus.in_use_rs2;
    assign bus.r_addr1 = bus.in_rs1;
    assign bus.r_addr2 = bus.in_rs2;

    // Only the low five address bits name an architectural register.
    assign w_zero1 = !bus.in_use_rs1 || bus.in_rs1[4:0] == 5'd0;
    assign w_zero2 = !bus.in_use_rs2 || bus.in_rs2[4:0] == 5'd0;
    assign w_ex1   = bus.ex_we && bus.ex_waddr[4:0] == bus.in_rs1[4:0];
    assign w_ex2   = bus.ex_we && bus.ex_waddr[4:0] == bus.in_rs2[4:0];
    assign w_mem1  = bus.mem_we && bus.mem_waddr[4:0] == bus.in_rs1[4:0];
    assign w_mem2  = bus.mem_we && bus.mem_waddr[4:0] == bus.in_rs2[4:0];

    // The operand value during a load-use hazard is irrelevant: nothing is accepted that cycle.
    assign w_op1 = w_zero1 ? '0 : w_ex1 ? bus.ex_wdata : w_mem1 ? bus.mem_wdata : bus.r_data1;
    assign w_op2 = w_zero2 ? '0 : w_ex2 ? bus.ex_wdata : w_mem2 ? bus.mem_wdata : bus.r_data2;

    assign w_hazard = bus.in_valid & bus.ex_is_load & ((!w_zero1 & w_ex1) | (!w_zero2 & w_ex2));

    assign bus.out_valid = r_state == S_FULL;
    assign bus.in_ready  = rdy_in & !flush_in & !w_hazard & (!bus.out_valid | bus.out_ready);
    assign w_accept      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_EMPTY;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (rdy_in)
            w_next = flush_in ? S_EMPTY :
                     w_accept ? S_FULL :
                     (r_state == S_FULL && bus.out_ready) ? S_EMPTY : r_state;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pc    <= '0;
            r_ctrl  <= '0;
            r_imm   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_rd    <= '0;
            r_rd_we <= 1'b0;
        end else if (w_accept) begin
            r_pc    <= bus.in_pc;
            r_ctrl  <= bus.in_ctrl;
            r_imm   <= bus.in_imm;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_rd    <= bus.in_rd;
            r_rd_we <= bus.in_rd_we;
        end
    end

    assign bus.out_pc    = r_pc;
    assign bus.out_ctrl  = r_ctrl;
    assign bus.out_imm   = r_imm;
    assign bus.out_op1   = r_op1;
    assign bus.out_op2   = r_op2;
    assign bus.out_rd    = r_rd;
    assign bus.out_rd_we = r_rd_we;

`ifdef IDOF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                          r_stall_cnt <= '0;
        else if (rdy_in & w_hazard & !flush_in) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
